// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: write-back staging queue in front of the integer regfile.
// Commits are queued in order and drained onto the regfile write ports up to
// NR_WB_PORTS per cycle. Queued and just-drained writes are forwarded to readers.
// Optional macro REGFILE_WB_BYPASS_EN: a write arriving at an empty queue with
// drain enabled goes straight to port 0 in the same cycle.
module regfile_wb_buffer #(
   parameter int DATA_WIDTH    = 64,
   parameter int DEPTH         = 4,
   parameter int NR_WB_PORTS   = 2,
   parameter int NR_READ_PORTS = 2
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        valid_i,
   output logic                                        ready_o,
   input  logic [4:0]                                  waddr_i,
   input  logic [DATA_WIDTH-1:0]                       wdata_i,
   input  logic                                        drain_en_i,
   output logic [NR_WB_PORTS-1:0]                      we_o,
   output logic [NR_WB_PORTS-1:0][4:0]                 waddr_o,
   output logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]      wdata_o,
   input  logic [NR_READ_PORTS-1:0][4:0]               raddr_i,
   output logic [NR_READ_PORTS-1:0]                    fwd_valid_o,
   output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]    fwd_data_o,
   output logic                                        empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]            addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;

   logic [NR_WB_PORTS-1:0]                 hold_valid_q;
   logic [NR_WB_PORTS-1:0][4:0]            hold_addr_q;
   logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0] hold_data_q;

   logic [NR_WB_PORTS-1:0] drain_we;
   logic [CW-1:0]          drained;
   logic                   drain_stop;
   logic                   drain_conflict;
   logic                   accept;
   logic                   bypass;

   // Physical slot of the k-th oldest entry (pointer wraps naturally at DEPTH)
   logic [PW-1:0] age_idx [DEPTH];
   logic [PW-1:0] port_idx [NR_WB_PORTS];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi] = head_q + PW'(gi);
   end

   for (genvar gi = 0; gi < NR_WB_PORTS; gi++) begin : g_port
      assign port_idx[gi] = head_q + PW'(gi);
   end

   assign ready_o = (count_q < CW'(DEPTH));

`ifdef REGFILE_WB_BYPASS_EN
   assign bypass = (count_q == '0) && drain_en_i && valid_i && (waddr_i != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   assign accept  = valid_i && ready_o && (waddr_i != 5'd0) && !bypass;
   assign count_d = count_q + CW'(accept) - drained;
   assign head_d  = head_q + PW'(drained);
   assign tail_d  = tail_q + PW'(accept);
   assign we_o    = drain_we;
   assign empty_o = (count_q == '0) && !(|hold_valid_q);

   // Drain selection: oldest-first, contiguous, stop at the first address repeat
   always_comb begin
      drain_we       = '0;
      waddr_o        = '0;
      wdata_o        = '0;
      drained        = '0;
      drain_stop     = 1'b0;
      drain_conflict = 1'b0;
      if (drain_en_i) begin
         if (bypass) begin
            drain_we[0] = 1'b1;
            waddr_o[0]  = waddr_i;
            wdata_o[0]  = wdata_i;
         end else begin
            for (int i = 0; i < NR_WB_PORTS; i++) begin
               if (!drain_stop && (int'(count_q) > i)) begin
                  drain_conflict = 1'b0;
                  for (int j = 0; j < i; j++) begin
                     if (addr_q[port_idx[j]] == addr_q[port_idx[i]]) begin
                        drain_conflict = 1'b1;
                     end
                  end
                  if (drain_conflict) begin
                     drain_stop = 1'b1;
                  end else begin
                     drain_we[i] = 1'b1;
                     waddr_o[i]  = addr_q[port_idx[i]];
                     wdata_o[i]  = data_q[port_idx[i]];
                     drained     = drained + CW'(1);
                  end
               end else begin
                  drain_stop = 1'b1;
               end
            end
         end
      end
   end

   // Forwarding: hold stage first, then queue entries oldest to youngest so the
   // youngest match wins and any queue match overrides the hold stage
   always_comb begin
      fwd_valid_o = '0;
      fwd_data_o  = '0;
      for (int r = 0; r < NR_READ_PORTS; r++) begin
         if (raddr_i[r] != 5'd0) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
               if (hold_valid_q[p] && (hold_addr_q[p] == raddr_i[r])) begin
                  fwd_valid_o[r] = 1'b1;
                  fwd_data_o[r]  = hold_data_q[p];
               end
            end
            for (int k = 0; k < DEPTH; k++) begin
               if ((int'(count_q) > k) && (addr_q[age_idx[k]] == raddr_i[r])) begin
                  fwd_valid_o[r] = 1'b1;
                  fwd_data_o[r]  = data_q[age_idx[k]];
               end
            end
         end
      end
   end

   // Queue storage, pointers and hold stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < DEPTH; k++) begin
            addr_q[k] <= '0;
            data_q[k] <= '0;
         end
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         hold_valid_q <= '0;
         hold_addr_q  <= '0;
         hold_data_q  <= '0;
      end else begin
         if (accept) begin
            addr_q[tail_q] <= waddr_i;
            data_q[tail_q] <= wdata_i;
         end
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         hold_valid_q <= drain_we;
         hold_addr_q  <= waddr_o;
         hold_data_q  <= wdata_o;
      end
   end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed testbench for regfile_wb_buffer (DEPTH=4, 2 drain ports, 2 read ports).
module tb_regfile_wb_buffer;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             valid = 1'b0;
   logic             ready;
   logic [4:0]       waddr = '0;
   logic [63:0]      wdata = '0;
   logic             drain_en = 1'b0;
   logic [1:0]       we;
   logic [1:0][4:0]  waddr_o;
   logic [1:0][63:0] wdata_o;
   logic [1:0][4:0]  raddr = '0;
   logic [1:0]       fwd_valid;
   logic [1:0][63:0] fwd_data;
   logic             empty;

   int checks = 0;
   int errors = 0;
   logic [63:0] rf [32];

   always #5 clk = ~clk;

   regfile_wb_buffer #(.DATA_WIDTH(64), .DEPTH(4), .NR_WB_PORTS(2), .NR_READ_PORTS(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
      .waddr_i(waddr), .wdata_i(wdata), .drain_en_i(drain_en),
      .we_o(we), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .raddr_i(raddr), .fwd_valid_o(fwd_valid), .fwd_data_o(fwd_data),
      .empty_o(empty)
   );

   // Regfile image built from the issued writes
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (we[i]) rf[waddr_o[i]] <= wdata_o[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one cycle of inputs just after the falling edge, settle, then return
   task automatic cyc(input logic v, input logic [4:0] a, input logic [63:0] d, input logic den);
      @(negedge clk);
      valid    = v;
      waddr    = a;
      wdata    = d;
      drain_en = den;
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_we", we, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ready", ready, 1);
      chk("rst_fwd", fwd_valid, 0);
      chk("rst_waddr", waddr_o, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_fwd_data", fwd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single write latency
      cyc(1, 5, 64'hA5, 1);
`ifdef REGFILE_WB_BYPASS_EN
      chk("t0_we", we, 2'b01);
      chk("t0_waddr", waddr_o[0], 5);
      chk("t0_wdata", wdata_o[0], 64'hA5);
      cyc(0, 0, 0, 1);
      chk("t1_we", we, 0);
`else
      chk("t0_we", we, 0);
      cyc(0, 0, 0, 1);
      chk("t1_we", we, 2'b01);
      chk("t1_waddr", waddr_o[0], 5);
      chk("t1_wdata", wdata_o[0], 64'hA5);
`endif
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("single_empty", empty, 1);

      // Fill with drain disabled
      for (int i = 1; i <= 4; i++) begin
         cyc(1, 5'(i), 64'(i * 16), 0);
         chk($sformatf("fill_ready%0d", i), ready, 1);
      end
      cyc(1, 5, 64'h55, 0);
      chk("full_ready", ready, 0);
      chk("full_we", we, 0);
      cyc(0, 0, 0, 1);
      chk("drain1_we", we, 2'b11);
      chk("drain1_a0", waddr_o[0], 1);
      chk("drain1_a1", waddr_o[1], 2);
      cyc(0, 0, 0, 1);
      chk("drain2_we", we, 2'b11);
      chk("drain2_a0", waddr_o[0], 3);
      chk("drain2_a1", waddr_o[1], 4);
      chk("drain2_d1", wdata_o[1], 64'h40);
      cyc(0, 0, 0, 1);
      chk("drain3_we", we, 0);
      chk("drain3_empty", empty, 0);
      cyc(0, 0, 0, 1);
      chk("drain4_empty", empty, 1);

      // Same-address conflict
      cyc(1, 7, 1, 0);
      cyc(1, 7, 2, 0);
      cyc(1, 8, 3, 0);
      cyc(0, 0, 0, 1);
      chk("conf1_we", we, 2'b01);
      chk("conf1_a0", waddr_o[0], 7);
      chk("conf1_d0", wdata_o[0], 1);
      cyc(0, 0, 0, 1);
      chk("conf2_we", we, 2'b11);
      chk("conf2_d0", wdata_o[0], 2);
      chk("conf2_a1", waddr_o[1], 8);
      chk("conf2_d1", wdata_o[1], 3);
      cyc(0, 0, 0, 1);
      chk("conf_rf_x7", rf[7], 2);
      cyc(0, 0, 0, 1);

      // Forwarding youngest queue entry, then hold stage
      raddr[0] = 9;
      cyc(1, 9, 64'h11, 0);
      chk("fwd_none", fwd_valid[0], 0);
      cyc(1, 9, 64'h22, 0);
      chk("fwd_old_v", fwd_valid[0], 1);
      chk("fwd_old_d", fwd_data[0], 64'h11);
      cyc(0, 0, 0, 0);
      chk("fwd_young_d", fwd_data[0], 64'h22);
      cyc(0, 0, 0, 1);
      chk("fwd_dr1_we", we, 2'b01);
      chk("fwd_dr1_d", fwd_data[0], 64'h22);
      cyc(0, 0, 0, 1);
      chk("fwd_dr2_we", we, 2'b01);
      chk("fwd_dr2_d", fwd_data[0], 64'h22);
      cyc(0, 0, 0, 1);
      chk("fwd_hold_v", fwd_valid[0], 1);
      chk("fwd_hold_d", fwd_data[0], 64'h22);
      cyc(0, 0, 0, 1);
      chk("fwd_gone_v", fwd_valid[0], 0);

      // x0 write is discarded
      raddr[0] = 0;
      cyc(1, 0, 64'hFF, 1);
      chk("x0_ready", ready, 1);
      chk("x0_we0", we, 0);
      cyc(0, 0, 0, 1);
      chk("x0_we1", we, 0);
      chk("x0_ready1", ready, 1);
      chk("x0_fwd", fwd_valid[0], 0);
      chk("x0_empty", empty, 1);

      // Reset mid-drain
      raddr[1] = 12;
      cyc(1, 10, 64'hA, 0);
      cyc(1, 11, 64'hB, 0);
      cyc(1, 12, 64'hC, 0);
      cyc(0, 0, 0, 1);
      chk("mid_we", we, 2'b11);
      chk("mid_fwd", fwd_valid[1], 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", we, 0);
      chk("mid_rst_fwd", fwd_valid, 0);
      chk("mid_rst_empty", empty, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1);
         chk($sformatf("post_we%0d", i), we, 0);
         chk($sformatf("post_empty%0d", i), empty, 1);
         chk($sformatf("post_ready%0d", i), ready, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
